// File: rtl/fp32_adder_datapath.sv
// fp32_adder_datapath
//   Pipelined IEEE-754 binary32 adder (out = in1 + in2). It accepts one
//   operand pair per clock and never stalls. A pair sampled on edge N
//   appears on out after edge N+3, with out_valid high for that one cycle.
//   Subnormal inputs and results are flushed to signed zero. Rounding is
//   round-to-nearest-even. Any NaN, or inf - inf, yields the canonical quiet
//   NaN 7FC00000.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; clears every pipeline register
//   in_valid  in1/in2 carry a valid pair this cycle
//   in1, in2  binary32 operands
//   out       registered sum; holds its last value while out_valid is low
//   out_valid out holds the result of the pair presented three edges earlier
//
// Pipeline
//   capture -> stage 1 unpack/align -> stage 2 add/sub -> stage 3 norm/round/pack
//   The 28-bit working format is {carry, significand[23:0], guard, round, sticky}.

module fp32_adder_datapath #(
  // Informational only. The datapath is fixed at three stages after capture,
  // so this must stay 3.
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        out_valid
);

  // valid chain: [0] capture, [1] stage 1, [2] stage 2, [LATENCY] output
  logic [LATENCY:0] vld_q, vld_d;

  // capture registers
  logic [31:0] opa_q, opa_d, opb_q, opb_d;

  // stage 1 registers
  logic        s1_sign_q,  s1_sign_d;
  logic        s1_sub_q,   s1_sub_d;
  logic [7:0]  s1_exp_q,   s1_exp_d;
  logic [23:0] s1_siga_q,  s1_siga_d;
  logic [25:0] s1_balgn_q, s1_balgn_d;
  logic        s1_bstk_q,  s1_bstk_d;
  logic        s1_nan_q,   s1_nan_d;
  logic        s1_inf_q,   s1_inf_d;
  logic        s1_infs_q,  s1_infs_d;
  logic        s1_zero_q,  s1_zero_d;
  logic        s1_zsgn_q,  s1_zsgn_d;

  // stage 2 registers
  logic        s2_sign_q,  s2_sign_d;
  logic [7:0]  s2_exp_q,   s2_exp_d;
  logic [27:0] s2_sum_q,   s2_sum_d;
  logic        s2_nan_q,   s2_nan_d;
  logic        s2_inf_q,   s2_inf_d;
  logic        s2_infs_q,  s2_infs_d;
  logic        s2_zero_q,  s2_zero_d;
  logic        s2_zsgn_q,  s2_zsgn_d;

  // output register
  logic [31:0] out_q, out_d;

  // stage 1 combinational helpers
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        za, zb, na, nb, ia, ib;
  logic [30:0] mag_a, mag_b;
  logic        swap;
  logic        big_zero, sml_zero;
  logic [7:0]  big_e, sml_e;
  logic [22:0] big_f, sml_f;
  logic [23:0] sml_sig;
  logic [7:0]  ediff;
  logic [49:0] ext;

  // stage 2 combinational helpers
  logic [27:0] a_ext, b_ext;

  // stage 3 combinational helpers
  logic [4:0]  lzc;
  logic [26:0] norm;
  logic [23:0] mant;
  logic        g_bit, r_bit, s_bit, round_up;
  logic [24:0] mant_r;
  logic [9:0]  exp_n, exp_r;
  logic [22:0] frac_o;
  logic [31:0] res;

  // capture
  always_comb begin
    vld_d = {vld_q[LATENCY-1:0], in_valid};
    opa_d = in_valid ? in1 : opa_q;
    opb_d = in_valid ? in2 : opb_q;
  end

  // stage 1: classify, order by magnitude, align the smaller operand
  always_comb begin
    sa = opa_q[31];
    ea = opa_q[30:23];
    fa = opa_q[22:0];
    sb = opb_q[31];
    eb = opb_q[30:23];
    fb = opb_q[22:0];

    za = (ea == '0);
    zb = (eb == '0);
    na = (ea == '1) && (fa != '0);
    nb = (eb == '1) && (fb != '0);
    ia = (ea == '1) && (fa == '0);
    ib = (eb == '1) && (fb == '0);

    // flushed subnormals compare as zero magnitude
    mag_a = za ? '0 : opa_q[30:0];
    mag_b = zb ? '0 : opb_q[30:0];
    swap  = (mag_b > mag_a);

    big_zero = swap ? zb : za;
    sml_zero = swap ? za : zb;
    big_e    = swap ? eb : ea;
    sml_e    = swap ? ea : eb;
    big_f    = swap ? fb : fa;
    sml_f    = swap ? fa : fb;
    sml_sig  = sml_zero ? '0 : {1'b1, sml_f};
    ediff    = big_e - sml_e;

    ext        = '0;
    s1_balgn_d = '0;
    s1_bstk_d  = 1'b0;
    if (ediff >= 8'd26) begin
      // the whole smaller operand lies below the round bit
      s1_bstk_d = |sml_sig;
    end else begin
      ext        = {sml_sig, 26'd0} >> ediff;
      s1_balgn_d = ext[49:24];
      s1_bstk_d  = |ext[23:0];
    end

    s1_sign_d = swap ? sb : sa;
    s1_sub_d  = sa ^ sb;
    s1_exp_d  = big_e;
    s1_siga_d = big_zero ? '0 : {1'b1, big_f};
    s1_nan_d  = na | nb | (ia & ib & (sa != sb));
    s1_inf_d  = ia | ib;
    s1_infs_d = ia ? sa : sb;
    s1_zero_d = za & zb;
    s1_zsgn_d = sa & sb;
  end

  // stage 2: significand add/subtract (A >= B, so no negative result)
  always_comb begin
    a_ext     = {1'b0, s1_siga_q, 3'b000};
    b_ext     = {1'b0, s1_balgn_q, s1_bstk_q};
    s2_sum_d  = s1_sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
    s2_sign_d = s1_sign_q;
    s2_exp_d  = s1_exp_q;
    s2_nan_d  = s1_nan_q;
    s2_inf_d  = s1_inf_q;
    s2_infs_d = s1_infs_q;
    s2_zero_d = s1_zero_q;
    s2_zsgn_d = s1_zsgn_q;
  end

  // stage 3: normalize, round to nearest even, pack
  always_comb begin
    lzc = 5'd0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (s2_sum_q[i]) lzc = 5'(26 - i);
    end
    norm = s2_sum_q[26:0] << lzc;

    if (s2_sum_q[27]) begin
      mant  = s2_sum_q[27:4];
      g_bit = s2_sum_q[3];
      r_bit = s2_sum_q[2];
      s_bit = |s2_sum_q[1:0];
      exp_n = {2'b00, s2_exp_q} + 10'd1;
    end else begin
      mant  = norm[26:3];
      g_bit = norm[2];
      r_bit = norm[1];
      s_bit = norm[0];
      exp_n = {2'b00, s2_exp_q} - {5'd0, lzc};
    end

    round_up = g_bit & (r_bit | s_bit | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    exp_r    = exp_n + {9'd0, mant_r[24]};
    frac_o   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (s2_nan_q)
      res = 32'h7FC0_0000;
    else if (s2_inf_q)
      res = {s2_infs_q, 8'hFF, 23'd0};
    else if (s2_zero_q)
      res = {s2_zsgn_q, 31'd0};
    else if (s2_sum_q == '0)
      res = '0;
    else if ($signed(exp_n) <= 10'sd0)
      res = {s2_sign_q, 31'd0};
    else if ($signed(exp_r) >= 10'sd255)
      res = {s2_sign_q, 8'hFF, 23'd0};
    else
      res = {s2_sign_q, exp_r[7:0], frac_o};

    out_d = vld_q[2] ? res : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_siga_q  <= '0;
      s1_balgn_q <= '0;
      s1_bstk_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_infs_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_zsgn_q  <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
      s2_nan_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_infs_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_zsgn_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      vld_q      <= vld_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      s1_sign_q  <= s1_sign_d;
      s1_sub_q   <= s1_sub_d;
      s1_exp_q   <= s1_exp_d;
      s1_siga_q  <= s1_siga_d;
      s1_balgn_q <= s1_balgn_d;
      s1_bstk_q  <= s1_bstk_d;
      s1_nan_q   <= s1_nan_d;
      s1_inf_q   <= s1_inf_d;
      s1_infs_q  <= s1_infs_d;
      s1_zero_q  <= s1_zero_d;
      s1_zsgn_q  <= s1_zsgn_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_sum_q   <= s2_sum_d;
      s2_nan_q   <= s2_nan_d;
      s2_inf_q   <= s2_inf_d;
      s2_infs_q  <= s2_infs_d;
      s2_zero_q  <= s2_zero_d;
      s2_zsgn_q  <= s2_zsgn_d;
      out_q      <= out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q[LATENCY];

endmodule

// File: tb/tb_fp32_adder_datapath.sv
// Testbench for fp32_adder_datapath. Directed vectors plus random pairs
// checked against a real-arithmetic reference model. Expected results are
// queued with the cycle they are due, and every cycle checks out/out_valid.

module tb_fp32_adder_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in1, in2;
  logic [31:0] out;
  logic        out_valid;

  always #5 clk = ~clk;

  fp32_adder_datapath #(.LATENCY(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .out_valid(out_valid)
  );

  typedef struct {
    int          due;
    logic [31:0] res;
    string       tag;
  } exp_t;

  exp_t        pend[$];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_out = '0;

  // Reference: exact sum in double precision, then round to binary32 (RNE)
  // with flush-to-zero and overflow to infinity.
  function automatic real to_real(input logic [31:0] x);
    logic [10:0] de;
    de = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], de, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, na, nb, ia, ib, za, zb, sg;
    logic [7:0]  ea, eb;
    real         s;
    logic [63:0] bits;
    int          fe;
    logic [24:0] keep;
    logic [28:0] rem;
    sa = a[31]; ea = a[30:23];
    sb = b[31]; eb = b[30:23];
    na = (ea == 8'hFF) && (a[22:0] != 0);
    nb = (eb == 8'hFF) && (b[22:0] != 0);
    ia = (ea == 8'hFF) && (a[22:0] == 0);
    ib = (eb == 8'hFF) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb) return 32'h7FC0_0000;
    if (ia && ib) return (sa != sb) ? 32'h7FC0_0000 : a;
    if (ia) return a;
    if (ib) return b;
    if (za && zb) return {sa & sb, 31'd0};
    if (za) return b;
    if (zb) return a;
    // Beyond 29 binades the double sum is no longer exact; the smaller operand
    // is then far below a quarter ulp of the larger, so the sum rounds to it.
    if (int'(ea) > int'(eb) + 29) return a;
    if (int'(eb) > int'(ea) + 29) return b;
    s = to_real(a) + to_real(b);
    if (s == 0.0) return 32'h0000_0000;
    bits = $realtobits(s);
    sg   = bits[63];
    fe   = int'(bits[62:52]) - 896;
    keep = {2'b01, bits[51:29]};
    rem  = bits[28:0];
    if (fe <= 0) return {sg, 31'd0};
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      fe   = fe + 1;
      keep = keep >> 1;
    end
    if (fe >= 255) return {sg, 8'hFF, 23'd0};
    return {sg, 8'(fe), keep[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (reset) begin
      pend.delete();
      last_out = '0;
    end
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      check({e.tag, " valid"}, {31'd0, out_valid}, 32'd1);
      check({e.tag, " data"}, out, e.res);
      last_out = e.res;
    end else begin
      check("idle valid", {31'd0, out_valid}, 32'd0);
      check("idle hold", out, last_out);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic v,
                       input logic [31:0] expv, input string tag);
    in1      = a;
    in2      = b;
    in_valid = v;
    if (v && !reset) pend.push_back('{due: cyc + 4, res: expv, tag: tag});
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  logic [31:0] edge_tbl [8];

  initial begin
    logic [31:0] a, b;
    logic [7:0]  e;
    int          mode;
    logic        v;

    edge_tbl = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0000,
                 32'h8000_0000, 32'h0040_0000, 32'h7F7F_FFFF, 32'h0080_0000};

    reset    = 1'b1;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;
    repeat (3) step();
    reset = 1'b0;

    // single exact cancellation, then a quiet pipeline
    issue(32'h3FC0_0000, 32'hBFC0_0000, 1'b1, 32'h0000_0000, "cancel 1.5-1.5");
    idle(5);

    // back-to-back
    issue(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, "b2b 1+2");
    issue(32'hBF80_0000, 32'h3F00_0000, 1'b1, 32'hBF00_0000, "b2b -1+0.5");
    issue(32'h3F80_0000, 32'h3380_0001, 1'b1, 32'h3F80_0001, "b2b above half");
    idle(4);

    // ties to even
    issue(32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F80_0000, "tie even down");
    issue(32'h3F80_0001, 32'h3380_0000, 1'b1, 32'h3F80_0002, "tie even up");
    idle(4);

    // overflow and specials
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, "overflow");
    issue(32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000, "inf-inf");
    issue(32'h7FC0_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, "nan in");
    issue(32'hFF80_0000, 32'h3F80_0000, 1'b1, 32'hFF80_0000, "-inf+1");
    idle(4);

    // zeros and subnormals
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, "-0+-0");
    issue(32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, "+0+-0");
    issue(32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, "ftz input");
    issue(32'h0080_0000, 32'h8080_0001, 1'b1, 32'h8000_0000, "underflow");
    idle(4);

    // random pairs with idle gaps, biased toward close exponents and specials
    for (int n = 0; n < 400; n++) begin
      mode = int'($urandom_range(0, 4));
      a    = $urandom;
      b    = $urandom;
      case (mode)
        1: begin
          e = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
          b = {b[31], e, b[22:0]};
        end
        2: b = {~a[31], a[30:3], b[2:0]};
        3: b = edge_tbl[$urandom_range(0, 7)];
        4: begin
          e = a[30:23] - 8'($urandom_range(20, 32));
          b = {b[31], e, b[22:0]};
        end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        a = a ^ b;
        b = a ^ b;
        a = a ^ b;
      end
      v = ($urandom_range(0, 3) != 0);
      issue(a, b, v, ref_add(a, b), $sformatf("rand %08h+%08h", a, b));
    end
    idle(5);

    // reset with two results in flight; neither may ever appear
    issue(32'h4000_0000, 32'h4000_0000, 1'b1, 32'h4080_0000, "flushed 1");
    issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4080_0000, "flushed 2");
    reset = 1'b1;
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, "during reset");
    reset = 1'b0;
    idle(6);

    // recovery after reset
    issue(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, "post reset");
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
